gb_fb_bank_ctrl: RTL

//  Double-buffer controller for the 160x144 GameBoy LCD framebuffer (2 banks x 23040 x 2b RAM).

---
 rtl/gb_video_pkg.sv | 18 +
 rtl/gb_fb_bank_ctrl_if.sv | 36 +++
 rtl/gb_fb_scan_addr.sv | 106 ++++++++++
 rtl/gb_fb_bank_ctrl.sv | 111 +++++++++++
 4 files changed

// File: rtl/gb_video_pkg.sv
// Shared GameBoy LCD geometry, VGA window placement and shade type for the
// framebuffer path.
package gb_video_pkg;

  localparam int GB_W   = 160;
  localparam int GB_H   = 144;
  localparam int ADDR_W = 15;
  localparam int SCALE  = 3;
  localparam int X_OFF  = 80;
  localparam int Y_OFF  = 24;

  typedef logic [1:0] gb_shade_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/gb_fb_bank_ctrl_if.sv
// PPU pixel conduit, VGA raster position and framebuffer RAM/scan-out side of
// the bank controller.
interface gb_fb_bank_ctrl_if #(
  parameter int ADDR_W = 15
);
  logic                      px_valid;
  gb_video_pkg::gb_shade_t   px_data;
  logic                      gb_frame_start;
  logic [15:0]               vga_lx;
  logic [15:0]               vga_ly;
  logic                      vga_frame_end;

  logic                      wr_en;
  logic                      wr_bank;
  logic [ADDR_W-1:0]         wr_addr;
  gb_video_pkg::gb_shade_t   wr_data;
  logic                      rd_bank;
  logic [ADDR_W-1:0]         rd_addr;
  logic                      rd_active;
  logic                      border;
  logic                      sync_err;
  logic [7:0]                drop_cnt;

  modport master (
    output px_valid, px_data, gb_frame_start, vga_lx, vga_ly, vga_frame_end,
    input  wr_en, wr_bank, wr_addr, wr_data, rd_bank, rd_addr, rd_active,
           border, sync_err, drop_cnt
  );

  modport slave (
    input  px_valid, px_data, gb_frame_start, vga_lx, vga_ly, vga_frame_end,
    output wr_en, wr_bank, wr_addr, wr_data, rd_bank, rd_addr, rd_active,
           border, sync_err, drop_cnt
  );

endinterface

// File: rtl/gb_fb_scan_addr.sv
// Maps the VGA raster onto scaled framebuffer read addresses using only
// counters and an adder; outputs are registered one cycle behind lx/ly.
module gb_fb_scan_addr #(
  parameter int GB_W   = gb_video_pkg::GB_W,
  parameter int GB_H   = gb_video_pkg::GB_H,
  parameter int ADDR_W = gb_video_pkg::ADDR_W,
  parameter int SCALE  = gb_video_pkg::SCALE,
  parameter int X_OFF  = gb_video_pkg::X_OFF,
  parameter int Y_OFF  = gb_video_pkg::Y_OFF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [15:0]       lx_i,
  input  logic [15:0]       ly_i,
  input  logic              frame_end_i,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic              rd_active_o,
  output logic              border_o
);

  localparam int CW = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int XW = (GB_W > 1) ? $clog2(GB_W + 1) : 1;

  localparam logic [15:0]       X_BEG     = 16'(X_OFF);
  localparam logic [15:0]       X_END     = 16'(X_OFF + GB_W * SCALE);
  localparam logic [15:0]       Y_BEG     = 16'(Y_OFF);
  localparam logic [15:0]       Y_END     = 16'(Y_OFF + GB_H * SCALE);
  localparam logic [CW-1:0]     SUB_LAST  = CW'(SCALE - 1);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(GB_W);

  logic              in_y, win, left_edge, row_step;
  logic [CW-1:0]     col_cnt_q, col_cnt_d, col_cur;
  logic [CW-1:0]     row_cnt_q, row_cnt_d;
  logic [XW-1:0]     gb_x_q, gb_x_d, gb_x_cur;
  logic [ADDR_W-1:0] line_base_q, line_base_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              rd_active_q, border_q, border_d;

  always_comb begin
    in_y      = (ly_i >= Y_BEG) && (ly_i < Y_END);
    win       = in_y && (lx_i >= X_BEG) && (lx_i < X_END);
    left_edge = (lx_i == X_BEG);
    row_step  = in_y && (lx_i == X_END);
    // The left edge restarts the column counters so a line never inherits
    // a stale horizontal phase from the previous one.
    col_cur   = left_edge ? '0 : col_cnt_q;
    gb_x_cur  = left_edge ? '0 : gb_x_q;

    col_cnt_d = col_cnt_q;
    gb_x_d    = gb_x_q;
    rd_addr_d = rd_addr_q;
    border_d  = 1'b0;
    if (win) begin
      rd_addr_d = line_base_q + ADDR_W'(gb_x_cur);
      border_d  = (col_cur == '0) || (row_cnt_q == '0);
      if (col_cur == SUB_LAST) begin
        col_cnt_d = '0;
        gb_x_d    = gb_x_cur + 1'b1;
      end else begin
        col_cnt_d = col_cur + 1'b1;
        gb_x_d    = gb_x_cur;
      end
    end
  end

  always_comb begin
    row_cnt_d   = row_cnt_q;
    line_base_d = line_base_q;
    if (frame_end_i) begin
      row_cnt_d   = '0;
      line_base_d = '0;
    end else if (row_step) begin
      if (row_cnt_q == SUB_LAST) begin
        row_cnt_d   = '0;
        line_base_d = line_base_q + LINE_STEP;
      end else begin
        row_cnt_d = row_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_cnt_q   <= '0;
      row_cnt_q   <= '0;
      gb_x_q      <= '0;
      line_base_q <= '0;
      rd_addr_q   <= '0;
      rd_active_q <= 1'b0;
      border_q    <= 1'b0;
    end else begin
      col_cnt_q   <= col_cnt_d;
      row_cnt_q   <= row_cnt_d;
      gb_x_q      <= gb_x_d;
      line_base_q <= line_base_d;
      rd_addr_q   <= rd_addr_d;
      rd_active_q <= win;
      border_q    <= border_d;
    end
  end

  assign rd_addr_o   = rd_addr_q;
  assign rd_active_o = rd_active_q;
  assign border_o    = border_q;

endmodule

// File: rtl/gb_fb_bank_ctrl.sv
// Double-buffered GameBoy framebuffer controller: PPU write sequencing into the
// back bank, tear-free bank swap at VGA frame end, scaled scan-out addressing.
module gb_fb_bank_ctrl #(
  parameter int GB_W   = gb_video_pkg::GB_W,
  parameter int GB_H   = gb_video_pkg::GB_H,
  parameter int ADDR_W = gb_video_pkg::ADDR_W,
  parameter int SCALE  = gb_video_pkg::SCALE,
  parameter int X_OFF  = gb_video_pkg::X_OFF,
  parameter int Y_OFF  = gb_video_pkg::Y_OFF
) (
  input  logic             clk,
  input  logic             reset_n,
  gb_fb_bank_ctrl_if.slave bus
);
  import gb_video_pkg::gb_shade_t;
  import gb_video_pkg::sat_inc8;

  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(GB_W * GB_H - 1);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, px_addr;
  logic              complete;
  logic              pending_q, pending_d;
  logic              rd_bank_q, rd_bank_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;
  logic              wr_en_q, wr_bank_q, sync_err_q;
  logic [ADDR_W-1:0] wr_addr_q;
  gb_shade_t         wr_data_q;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_active, border;

  // A frame start rebases the pixel that arrives with it to address 0.
  always_comb begin
    px_addr  = bus.gb_frame_start ? '0 : wr_ptr_q;
    complete = bus.px_valid && (px_addr == LAST_PIX);
    wr_ptr_d = px_addr;
    if (bus.px_valid)
      wr_ptr_d = complete ? '0 : px_addr + 1'b1;
  end

  // Completion outranks the swap: a frame finishing on the vblank cycle is
  // only shown at the following vblank.
  always_comb begin
    pending_d  = pending_q;
    rd_bank_d  = rd_bank_q;
    drop_cnt_d = drop_cnt_q;
    if (complete) begin
      if (pending_q)
        drop_cnt_d = sat_inc8(drop_cnt_q);
      pending_d = 1'b1;
    end else if (bus.vga_frame_end && pending_q) begin
      rd_bank_d = ~rd_bank_q;
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      pending_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      drop_cnt_q <= '0;
      wr_en_q    <= 1'b0;
      wr_bank_q  <= 1'b1;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      sync_err_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      pending_q  <= pending_d;
      rd_bank_q  <= rd_bank_d;
      drop_cnt_q <= drop_cnt_d;
      wr_en_q    <= bus.px_valid;
      sync_err_q <= bus.gb_frame_start && (wr_ptr_q != '0);
      if (bus.px_valid) begin
        wr_addr_q <= px_addr;
        wr_data_q <= bus.px_data;
        wr_bank_q <= ~rd_bank_q;
      end
    end
  end

  gb_fb_scan_addr #(
    .GB_W   (GB_W),
    .GB_H   (GB_H),
    .ADDR_W (ADDR_W),
    .SCALE  (SCALE),
    .X_OFF  (X_OFF),
    .Y_OFF  (Y_OFF)
  ) u_scan (
    .clk         (clk),
    .reset_n     (reset_n),
    .lx_i        (bus.vga_lx),
    .ly_i        (bus.vga_ly),
    .frame_end_i (bus.vga_frame_end),
    .rd_addr_o   (rd_addr),
    .rd_active_o (rd_active),
    .border_o    (border)
  );

  assign bus.wr_en     = wr_en_q;
  assign bus.wr_bank   = wr_bank_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.rd_bank   = rd_bank_q;
  assign bus.rd_addr   = rd_addr;
  assign bus.rd_active = rd_active;
  assign bus.border    = border;
  assign bus.sync_err  = sync_err_q;
  assign bus.drop_cnt  = drop_cnt_q;

endmodule
